// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes and the channel FSM state types.
package axil_pkg;

   localparam logic [1:0] AXI_OKAY   = 2'b00;
   localparam logic [1:0] AXI_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      R_IDLE,
      R_WAIT,
      R_RESP
   } rd_state_e;

   typedef enum logic [1:0] {
      W_IDLE,
      W_WAIT,
      W_RESP
   } wr_state_e;

endpackage

// File: rtl/axil_sram_slave_sram_bank.sv
// Word-organised SRAM: combinational read port, one synchronous byte-enabled write port.
module sram_bank #(
   parameter int DEPTH = 1024,
   parameter int IDX_W = 10
) (
   input  logic             clk,
   input  logic [IDX_W-1:0] ridx,
   output logic [31:0]      rdata,
   input  logic             we,
   input  logic [IDX_W-1:0] widx,
   input  logic [31:0]      wdata,
   input  logic [3:0]       wstrb
);

   logic [31:0] mem [DEPTH];

   assign rdata = mem[ridx];

   // Commit only the enabled byte lanes; contents are deliberately never reset.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

endmodule

// File: rtl/axil_sram_slave.sv
// AXI4-Lite responder for an on-chip SRAM with independent, fixed-latency read and write channels.
module axil_sram_slave
   import axil_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0f00_0000,
   parameter int          DEPTH     = 1024,
   parameter int          READ_LAT  = 1,
   parameter int          WRITE_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] araddr,
   input  logic [2:0]  arsize,
   input  logic        arvalid,
   output logic        arready,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rvalid,
   input  logic        rready,
   input  logic [31:0] awaddr,
   input  logic [2:0]  awsize,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wvalid,
   output logic        wready,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Transfer size is irrelevant: the full aligned word is always used.
   logic unused_size;
   assign unused_size = ^{arsize, awsize};

   function automatic logic in_range(input logic [31:0] a);
      return (a >= BASE_ADDR) && ((a - BASE_ADDR) < 32'(4 * DEPTH));
   endfunction

   function automatic logic [IDX_W-1:0] to_idx(input logic [31:0] a);
      return IDX_W'((a - BASE_ADDR) >> 2);
   endfunction

   rd_state_e   rstate, rnext;
   wr_state_e   wstate, wnext;
   logic [31:0] raddr_q, rd_addr, mem_rdata;
   logic [3:0]  rcnt, wcnt;
   logic        r_enter, w_enter;
   logic        aw_got, w_got, aw_hs, w_hs;
   logic [31:0] awaddr_q, wdata_q, eff_awaddr, eff_wdata;
   logic [3:0]  wstrb_q, eff_wstrb;

   // With zero latency the sample happens in the handshake cycle, so read the live address.
   assign rd_addr    = (rstate == R_IDLE) ? araddr : raddr_q;
   assign eff_awaddr = aw_got ? awaddr_q : awaddr;
   assign eff_wdata  = w_got  ? wdata_q  : wdata;
   assign eff_wstrb  = w_got  ? wstrb_q  : wstrb;
   assign awready    = (wstate == W_IDLE) && !aw_got;
   assign wready     = (wstate == W_IDLE) && !w_got;
   assign aw_hs      = awvalid && awready;
   assign w_hs       = wvalid && wready;
   assign r_enter    = (rnext == R_RESP) && (rstate != R_RESP);
   assign w_enter    = (wnext == W_RESP) && (wstate != W_RESP);

   sram_bank #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_bank (
      .clk   (clk),
      .ridx  (to_idx(rd_addr)),
      .rdata (mem_rdata),
      .we    (w_enter && in_range(eff_awaddr)),
      .widx  (to_idx(eff_awaddr)),
      .wdata (eff_wdata),
      .wstrb (eff_wstrb)
   );

   // Read channel state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rstate <= R_IDLE;
      else     rstate <= rnext;
   end

   // Read channel next state and handshake outputs.
   always_comb begin
      rnext   = rstate;
      arready = 1'b0;
      rvalid  = 1'b0;
      case (rstate)
         R_IDLE: begin
            arready = 1'b1;
            if (arvalid) rnext = (READ_LAT == 0) ? R_RESP : R_WAIT;
         end
         R_WAIT: if (rcnt <= 4'd1) rnext = R_RESP;
         R_RESP: begin
            rvalid = 1'b1;
            if (rready) rnext = R_IDLE;
         end
         default: rnext = R_IDLE;
      endcase
   end

   // Read latency counter and response registers; response is frozen until accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rcnt  <= 4'd0;
         rdata <= 32'd0;
         rresp <= AXI_OKAY;
      end else begin
         if (rstate == R_IDLE && arvalid) rcnt <= 4'(READ_LAT);
         else if (rstate == R_WAIT && rcnt != 4'd0) rcnt <= rcnt - 4'd1;
         if (r_enter) begin
            rdata <= in_range(rd_addr) ? mem_rdata : 32'd0;
            rresp <= in_range(rd_addr) ? AXI_OKAY : AXI_SLVERR;
         end
      end
   end

   // Read address latch.
   always_ff @(posedge clk) begin
      if (rstate == R_IDLE && arvalid) raddr_q <= araddr;
   end

   // Write channel state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) wstate <= W_IDLE;
      else     wstate <= wnext;
   end

   // Write channel next state; leaves idle once both AW and W are held or arriving.
   always_comb begin
      wnext  = wstate;
      bvalid = 1'b0;
      case (wstate)
         W_IDLE: if ((aw_got || aw_hs) && (w_got || w_hs))
                    wnext = (WRITE_LAT == 0) ? W_RESP : W_WAIT;
         W_WAIT: if (wcnt <= 4'd1) wnext = W_RESP;
         W_RESP: begin
            bvalid = 1'b1;
            if (bready) wnext = W_IDLE;
         end
         default: wnext = W_IDLE;
      endcase
   end

   // Write capture flags, latency counter and response code.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         aw_got <= 1'b0;
         w_got  <= 1'b0;
         wcnt   <= 4'd0;
         bresp  <= AXI_OKAY;
      end else begin
         if (aw_hs) aw_got <= 1'b1;
         if (w_hs)  w_got  <= 1'b1;
         if (bvalid && bready) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
         end
         if (wstate == W_IDLE && wnext == W_WAIT) wcnt <= 4'(WRITE_LAT);
         else if (wstate == W_WAIT && wcnt != 4'd0) wcnt <= wcnt - 4'd1;
         if (w_enter) bresp <= in_range(eff_awaddr) ? AXI_OKAY : AXI_SLVERR;
      end
   end

   // Write address/data latches.
   always_ff @(posedge clk) begin
      if (aw_hs) awaddr_q <= awaddr;
      if (w_hs) begin
         wdata_q <= wdata;
         wstrb_q <= wstrb;
      end
   end

endmodule

// File: tb/tb_axil_sram_slave.sv
// Directed plus randomized bench for axil_sram_slave against a word-array reference model.
module tb_axil_sram_slave;

   localparam logic [31:0] BASE  = 32'h0f00_0000;
   localparam int          DEPTH = 1024;
   localparam int          RL    = 2;
   localparam int          WL    = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] araddr = '0;
   logic [2:0]  arsize = 3'd2;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b0;
   logic [31:0] awaddr = '0;
   logic [2:0]  awsize = 3'd2;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b0;

   int checks = 0;
   int passed = 0;
   int failed = 0;

   logic [31:0] model [DEPTH];

   axil_sram_slave #(
      .BASE_ADDR (BASE),
      .DEPTH     (DEPTH),
      .READ_LAT  (RL),
      .WRITE_LAT (WL)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .araddr  (araddr),
      .arsize  (arsize),
      .arvalid (arvalid),
      .arready (arready),
      .rdata   (rdata),
      .rresp   (rresp),
      .rvalid  (rvalid),
      .rready  (rready),
      .awaddr  (awaddr),
      .awsize  (awsize),
      .awvalid (awvalid),
      .awready (awready),
      .wdata   (wdata),
      .wstrb   (wstrb),
      .wvalid  (wvalid),
      .wready  (wready),
      .bresp   (bresp),
      .bvalid  (bvalid),
      .bready  (bready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit m_in(input logic [31:0] a);
      return (a >= BASE) && (a < BASE + 32'(4 * DEPTH));
   endfunction

   function automatic int m_idx(input logic [31:0] a);
      return int'((a - BASE) / 4);
   endfunction

   function automatic void m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      if (m_in(a)) begin
         for (int b = 0; b < 4; b++)
            if (s[b]) model[m_idx(a)][8*b +: 8] = d[8*b +: 8];
      end
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Count cycles from the handshake edge until bvalid, then check response and accept it.
   task automatic finish_write(input string tag, input logic [31:0] a);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bvalid && n < 20);
      check({tag, "/blat"}, 32'(n), 32'(1 + WL));
      check({tag, "/bresp"}, 32'(bresp), m_in(a) ? 32'd0 : 32'd2);
      bready = 1'b1;
      next_cycle();
   endtask

   task automatic axi_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
      awaddr = a; wdata = d; wstrb = s;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      @(negedge clk);
      check({tag, "/awready"}, 32'(awready & wready), 32'd1);
      next_cycle();
      awvalid = 1'b0; wvalid = 1'b0;
      m_write(a, d, s);
      finish_write(tag, a);
   endtask

   task automatic axi_read(input string tag, input logic [31:0] a);
      int n = 0;
      araddr = a; arvalid = 1'b1; rready = 1'b1;
      @(negedge clk);
      check({tag, "/arready"}, 32'(arready), 32'd1);
      next_cycle();
      arvalid = 1'b0;
      do begin
         @(negedge clk);
         n++;
      end while (!rvalid && n < 20);
      check({tag, "/rlat"}, 32'(n), 32'(1 + RL));
      check({tag, "/rdata"}, rdata, m_in(a) ? model[m_idx(a)] : 32'd0);
      check({tag, "/rresp"}, 32'(rresp), m_in(a) ? 32'd0 : 32'd2);
      next_cycle();
   endtask

   initial begin
      logic [31:0] a, d, held;
      int n;

      // Asynchronous reset: outputs settle before any clock edge.
      #2 rst = 1'b1;
      #1;
      check("rst/arready", 32'(arready), 32'd1);
      check("rst/awready", 32'(awready), 32'd1);
      check("rst/wready", 32'(wready), 32'd1);
      check("rst/rvalid", 32'(rvalid), 32'd0);
      check("rst/bvalid", 32'(bvalid), 32'd0);
      check("rst/rdata", rdata, 32'd0);
      check("rst/resp", {28'd0, rresp, bresp}, 32'd0);
      #9 rst = 1'b0;
      next_cycle();

      // Full-word write then read with unaligned address.
      axi_write("w_full", BASE + 32'h4, 32'hDEADBEEF, 4'hF);
      axi_read("r_full", BASE + 32'h6);
      check("r_full/const", model[1], 32'hDEADBEEF);

      // Single byte lane.
      axi_write("w_byte", BASE + 32'h6, 32'h00AB0000, 4'b0100);
      axi_read("r_byte", BASE + 32'h4);
      check("r_byte/const", model[1], 32'hDEABBEEF);

      // Empty strobe: OKAY, no change.
      axi_write("w_nostrb", BASE + 32'h4, 32'h12345678, 4'h0);
      axi_read("r_nostrb", BASE + 32'h4);

      // Seed a small region and the top word.
      for (int i = 0; i < 16; i++) axi_write("seed", BASE + 32'(4 * i), $urandom, 4'hF);
      axi_write("seed_top", BASE + 32'(4 * DEPTH - 4), 32'hA5A5_5A5A, 4'hF);

      // AW first, W four cycles later.
      awaddr = BASE + 32'h8; awvalid = 1'b1; wvalid = 1'b0;
      next_cycle();
      awvalid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("split/awready", 32'(awready), 32'd0);
         check("split/wready", 32'(wready), 32'd1);
         check("split/bvalid", 32'(bvalid), 32'd0);
         next_cycle();
      end
      wdata = 32'h0BAD_F00D; wstrb = 4'hF; wvalid = 1'b1;
      @(negedge clk);
      check("split/awready_w", 32'(awready), 32'd0);
      check("split/wready_w", 32'(wready), 32'd1);
      next_cycle();
      wvalid = 1'b0;
      m_write(BASE + 32'h8, 32'h0BAD_F00D, 4'hF);
      finish_write("split", BASE + 32'h8);
      axi_read("r_split", BASE + 32'h8);

      // Out of range on both sides and top-word boundary.
      axi_read("r_oor_hi", 32'h1000_0000);
      axi_read("r_oor_edge", BASE + 32'(4 * DEPTH));
      axi_write("w_oor_lo", 32'h0eff_fffc, 32'hFFFF_FFFF, 4'hF);
      axi_read("r_top", BASE + 32'(4 * DEPTH - 4));
      check("r_top/const", model[DEPTH-1], 32'hA5A5_5A5A);

      // Read response stalled by rready.
      araddr = BASE + 32'h4; arvalid = 1'b1; rready = 1'b0;
      next_cycle();
      arvalid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rvalid && n < 20);
      check("stall/rlat", 32'(n), 32'(1 + RL));
      held = model[1];
      for (int c = 0; c < 5; c++) begin
         next_cycle();
         @(negedge clk);
         check("stall/rvalid", 32'(rvalid), 32'd1);
         check("stall/rdata", rdata, held);
         check("stall/arready", 32'(arready), 32'd0);
      end
      rready = 1'b1;
      next_cycle();
      @(negedge clk);
      check("stall/arready_after", 32'(arready), 32'd1);
      check("stall/rvalid_after", 32'(rvalid), 32'd0);
      next_cycle();

      // Reset while the write waits: no commit, no response.
      awaddr = BASE + 32'hC; wdata = 32'h7777_7777; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      next_cycle();
      awvalid = 1'b0; wvalid = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("wrst/bvalid", 32'(bvalid), 32'd0);
      check("wrst/ready", 32'(awready & wready & arready), 32'd1);
      #1 rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check("wrst/bvalid_hold", 32'(bvalid), 32'd0);
      end
      next_cycle();
      axi_read("wrst/r", BASE + 32'hC);

      // Randomized mix of reads and writes.
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 4) == 0) begin
            a = ($urandom_range(0, 1) == 1) ? BASE + 32'h1000 + 32'(4 * $urandom_range(0, 63))
                                           : BASE - 32'd4 - 32'(4 * $urandom_range(0, 63));
         end else begin
            n = $urandom_range(0, 16);
            if (n == 16) n = DEPTH - 1;
            a = BASE + 32'(4 * n) + 32'($urandom_range(0, 3));
         end
         d = $urandom;
         if ($urandom_range(0, 1) == 1) axi_write("rnd_w", a, d, 4'($urandom));
         else axi_read("rnd_r", a);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
